user_rd_reg: RTL
================

Name: user_rd_reg

Overview:
- JTAG user read register: parallel-in, serial-out. It is the readback counterpart of the user write register.
- Tracks a CLK25-domain data source and freezes a snapshot while the JTAG function is selected. Loads the snapshot into a DRCK-domain shift register at Capture-DR and shifts it out on TDO, or on DSY_OUT when daisy-chained.
- On the selected Update-DR, pulses an acknowledge back to the source, in the CLK25 domain.

Parameters:
- width, 8, data bits captured and shifted (minimum 2).
- def_value, 0, reset value of the snapshot register.

Ports:
- CLK25  input  1  fabric clock; runs the snapshot logic and the FSM.
- RST  input  1  reset, asynchronous, active-high; clears both clock domains.
- DRCK  input  1  JTAG data register clock.
- FSEL  input  1  function select for individual access.
- SEL  input  1  user JTAG instruction active.
- TDI  input  1  serial test data in.
- DSY_IN  input  1  daisy-chain serial input.
- CAPTURE  input  1  TAP in Capture-DR.
- SHIFT  input  1  TAP in Shift-DR.
- UPDATE  input  1  TAP in Update-DR.
- DSY_CHAIN  input  1  daisy-chain mode.
- PI  input  width  parallel data from the source (CLK25 domain).
- PI_VALID  input  1  CLK25 strobe: PI holds new data.
- TDO  output  1  FSEL & sr[0].
- DSY_OUT  output  1  DSY_CHAIN & sr[0].
- RD_ACK  output  1  one-CLK25 pulse when the read is committed.
- FROZEN  output  1  snapshot held for JTAG.
- OVERRUN  output  1  sticky: PI_VALID was dropped while FROZEN.

Behaviour:
- Definition: act = SEL & (FSEL | DSY_CHAIN); din = DSY_CHAIN ? DSY_IN : TDI.
- Synchronisers: act and UPDATE each pass through 2-flop synchronisers in CLK25, giving act_s and upd_s. A third flop holds the previous upd_s for edge detection: upd_rise = upd_s & !upd_s_d.
- Reset values:
  - snap = def_value; sr = 0.
  - FSM = IDLE; NEW = 0.
  - FROZEN = 0; OVERRUN = 0; RD_ACK = 0.
  - All synchroniser flops = 0.
- FSM (CLK25):
  - IDLE: FROZEN = 0.
    - PI_VALID=1 → snap <= PI and NEW <= 1.
    - act_s=1 → FROZE. A PI_VALID on that same cycle is still loaded.
  - FROZE: FROZEN = 1; snap holds.
    - PI_VALID=1 → OVERRUN <= 1 and the data is discarded.
    - upd_rise=1 (only while act_s=1) → ACK.
    - act_s=0 with no update → IDLE, no acknowledge, NEW unchanged.
    - If upd_rise and act_s fall in the same cycle, ACK wins.
  - ACK: RD_ACK = 1 for exactly one cycle; NEW <= 0; next state DONE.
  - DONE: FROZEN = 1; wait for act_s=0, then → IDLE. This prevents a second acknowledge within the same selection. Another upd_rise while in DONE produces no acknowledge.
- Snapshot latency: PI is in snap 1 CLK25 cycle after PI_VALID.
- Freeze latency: FROZEN asserts 3 CLK25 cycles after act rises.
- Usage constraint: act must be stable at least 4 CLK25 periods before the Capture-DR DRCK edge. A CLK25 much faster than TCK meets this.
- Shift register sr (posedge DRCK or posedge RST), priority order:
  - RST → 0.
  - CAPTURE & act → sr <= capture vector.
  - SHIFT & act → sr <= {din, sr[width-1:1]} (shift right, LSB first out).
  - Otherwise hold.
- Capture vector: snap, or per the optional feature.
- TDI data is discarded after shifting through; nothing parallel-loads from it.
- OVERRUN clears only on RST or in the ACK state. A clear in ACK is overridden by a PI_VALID in that same cycle.
- RST mid-shift: sr clears immediately and TDO goes to 0. The FSM returns to IDLE without an acknowledge.

Optional Feature:
- Macro USER_RD_REG_STATUS_EN.
- Defined: the shift register is width+2 bits and the capture vector is {snap, OVERRUN, NEW}. NEW is shifted out first, then OVERRUN. Total shift length is width+2.
- Undefined: the shift register is width bits and the capture vector is snap. NEW and OVERRUN are still maintained internally, and OVERRUN is still output.

Test Plan:
- Reset, then select with no PI_VALID; capture and shift 8 bits → TDO sequence = def_value LSB first (all 0); RD_ACK pulses once after Update.
- PI=8'hA5, PI_VALID; FSEL=SEL=1; capture, shift 8 → TDO bits 1,0,1,0,0,1,0,1; FROZEN=1 from 3 cycles after select until act drops.
- While FROZEN, PI=8'h3C with PI_VALID → snap stays 8'hA5 and OVERRUN=1. After Update: RD_ACK=1 for 1 cycle and OVERRUN=0.
- DSY_CHAIN=1, FSEL=0, DSY_IN pattern → DSY_OUT = captured snap, followed by DSY_IN delayed width DRCK cycles; TDO stays 0.
- Select, then deselect without Update → no RD_ACK, return to IDLE, NEW still 1. A subsequent PI_VALID with 8'h11 updates snap.
- With USER_RD_REG_STATUS_EN: PI=8'hFF, read → first two TDO bits are NEW=1, OVERRUN=0, then 8 ones. Assert RST mid-shift → TDO=0 immediately.

Source files
------------

// File: rtl/user_rd_reg_if.sv
// rtl/user_rd_reg_if.sv - JTAG TAP, source data and status signals of the user read register
interface user_rd_reg_if #(
  parameter int width = 8
);
  logic             FSEL;
  logic             SEL;
  logic             TDI;
  logic             DSY_IN;
  logic             CAPTURE;
  logic             SHIFT;
  logic             UPDATE;
  logic             DSY_CHAIN;
  logic [width-1:0] PI;
  logic             PI_VALID;
  logic             TDO;
  logic             DSY_OUT;
  logic             RD_ACK;
  logic             FROZEN;
  logic             OVERRUN;

  modport master (
    output FSEL, SEL, TDI, DSY_IN, CAPTURE, SHIFT, UPDATE, DSY_CHAIN, PI, PI_VALID,
    input  TDO, DSY_OUT, RD_ACK, FROZEN, OVERRUN
  );

  modport slave (
    input  FSEL, SEL, TDI, DSY_IN, CAPTURE, SHIFT, UPDATE, DSY_CHAIN, PI, PI_VALID,
    output TDO, DSY_OUT, RD_ACK, FROZEN, OVERRUN
  );
endinterface

// File: rtl/user_rd_reg.sv
// rtl/user_rd_reg.sv - JTAG user read register: CLK25 snapshot, DRCK parallel-in/serial-out
// USER_RD_REG_STATUS_EN prepends {OVERRUN, NEW} to the shifted word (NEW leaves first).
module user_rd_reg #(
  parameter int               width     = 8,
  parameter logic [width-1:0] def_value = '0
) (
  input  logic          CLK25,
  input  logic          RST,
  input  logic          DRCK,
  user_rd_reg_if.slave  bus
);

`ifdef USER_RD_REG_STATUS_EN
  localparam int sr_w = width + 2;
`else
  localparam int sr_w = width;
`endif

  typedef enum logic [1:0] {IDLE, FROZE, ACK, DONE} state_t;

  logic act;
  logic din;

  assign act = bus.SEL & (bus.FSEL | bus.DSY_CHAIN);
  assign din = bus.DSY_CHAIN ? bus.DSY_IN : bus.TDI;

  // CLK25 view of the TAP selection and Update-DR
  logic act_m;
  logic act_s;
  logic upd_m;
  logic upd_s;
  logic upd_s_d;
  logic upd_rise;

  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      act_m   <= 1'b0;
      act_s   <= 1'b0;
      upd_m   <= 1'b0;
      upd_s   <= 1'b0;
      upd_s_d <= 1'b0;
    end else begin
      act_m   <= act;
      act_s   <= act_m;
      upd_m   <= bus.UPDATE;
      upd_s   <= upd_m;
      upd_s_d <= upd_s;
    end
  end

  assign upd_rise = upd_s & ~upd_s_d;

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] snap;
  logic [width-1:0] snap_nxt;
  logic             new_q;
  logic             new_nxt;
  logic             ovr_q;
  logic             ovr_nxt;
  logic             rd_ack;
  logic             frozen;

  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      snap  <= def_value;
      new_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      snap  <= snap_nxt;
      new_q <= new_nxt;
      ovr_q <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    new_nxt   = new_q;
    ovr_nxt   = ovr_q;
    rd_ack    = 1'b0;
    frozen    = 1'b1;
    case (state)
      IDLE: begin
        frozen = 1'b0;
        if (bus.PI_VALID) begin
          snap_nxt = bus.PI;
          new_nxt  = 1'b1;
        end
        if (act_s) state_nxt = FROZE;
      end
      FROZE: begin
        if (bus.PI_VALID) ovr_nxt = 1'b1;
        // an update landing together with the deselect still commits the read
        if (upd_rise)    state_nxt = ACK;
        else if (!act_s) state_nxt = IDLE;
      end
      ACK: begin
        rd_ack    = 1'b1;
        new_nxt   = 1'b0;
        ovr_nxt   = bus.PI_VALID;
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.PI_VALID) ovr_nxt = 1'b1;
        if (!act_s)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [sr_w-1:0] cap_vec;
  logic [sr_w-1:0] sr;

`ifdef USER_RD_REG_STATUS_EN
  assign cap_vec = {snap, ovr_q, new_q};
`else
  assign cap_vec = snap;
`endif

  // snap is quasi-static here: act settles in CLK25 well before Capture-DR
  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      sr <= '0;
    end else if (bus.CAPTURE && act) begin
      sr <= cap_vec;
    end else if (bus.SHIFT && act) begin
      sr <= {din, sr[sr_w-1:1]};
    end
  end

  assign bus.TDO     = bus.FSEL & sr[0];
  assign bus.DSY_OUT = bus.DSY_CHAIN & sr[0];
  assign bus.RD_ACK  = rd_ack;
  assign bus.FROZEN  = frozen;
  assign bus.OVERRUN = ovr_q;

endmodule
